// File: rtl/menu_screen_if.sv
// ============================================================================
//  vga_if
//  VGA timing and colour bundle passed between the timing generator,
//  the menu picture generator and the output selector.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

`default_nettype wire

// File: rtl/menu_screen.sv
// ============================================================================
//  menu_screen
//  Main-menu picture generator and menu navigation state machine.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module menu_screen #(
    parameter logic [3:0]  KEY_NONE   = 4'h0,
    parameter logic [3:0]  KEY_UP     = 4'h2,
    parameter logic [3:0]  KEY_DOWN   = 4'h3,
    parameter logic [3:0]  KEY_ENTER  = 4'h4,
    parameter logic [3:0]  KEY_ESC    = 4'hF,
    parameter int          N_ITEMS    = 3,
    parameter int          ITEM_X     = 412,
    parameter int          ITEM_Y0    = 200,
    parameter int          ITEM_PITCH = 120,
    parameter int          ITEM_W     = 200,
    parameter int          ITEM_H     = 80,
    parameter logic [11:0] BG_RGB     = 12'h113,
    parameter logic [11:0] ITEM_RGB   = 12'h888,
    parameter logic [11:0] SEL_RGB    = 12'hFF0,
    parameter logic [11:0] PANEL_RGB  = 12'h046
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key,
    vga_if.in          in,
    vga_if.out         out,
    output logic [3:0] menu_state
);

    typedef enum logic [0:0] {
        ST_MAIN = 1'b0,
        ST_SUB  = 1'b1
    } state_t;

    localparam logic [1:0]  SEL_MAX  = 2'(N_ITEMS - 1);
    localparam logic [10:0] X_LO     = 11'(ITEM_X);
    localparam logic [10:0] X_HI     = 11'(ITEM_X + ITEM_W);
    localparam logic [10:0] PANEL_LO = 11'd100;
    localparam logic [10:0] PANEL_XH = 11'd924;
    localparam logic [10:0] PANEL_YH = 11'd668;

    state_t      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [1:0]  disp_sel_q, disp_sel_d;
    logic [3:0]  key_prev_q, key_prev_d;
    logic [3:0]  menu_state_q, menu_state_d;
    logic [11:0] rgb_q, rgb_d;
    logic [10:0] hcount_q, hcount_d, vcount_q, vcount_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d;
    logic        hblnk_q, hblnk_d, vblnk_q, vblnk_d;

    logic               key_event;
    logic               in_x;
    logic               in_panel;
    logic [N_ITEMS-1:0] in_box;
    logic               unused_in_rgb;

    assign unused_in_rgb = ^in.rgb;
    assign key_event     = (key != key_prev_q) && (key != KEY_NONE);

    assign in_x     = (in.hcount >= X_LO) && (in.hcount < X_HI);
    assign in_panel = (in.hcount >= PANEL_LO) && (in.hcount < PANEL_XH) &&
                      (in.vcount >= PANEL_LO) && (in.vcount < PANEL_YH);

    // Box bounds fold to constants per item; no runtime multiply.
    for (genvar i = 0; i < N_ITEMS; i++) begin : g_box
        localparam logic [10:0] Y_LO = 11'(ITEM_Y0 + i * ITEM_PITCH);
        localparam logic [10:0] Y_HI = 11'(ITEM_Y0 + i * ITEM_PITCH + ITEM_H);
        assign in_box[i] = in_x && (in.vcount >= Y_LO) && (in.vcount < Y_HI);
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        menu_state_d = menu_state_q;
        if (key_event) begin
            case (state_q)
                ST_MAIN: begin
                    case (key)
                        KEY_UP:    sel_d = (sel_q == 2'd0) ? SEL_MAX : sel_q - 2'd1;
                        KEY_DOWN:  sel_d = (sel_q == SEL_MAX) ? 2'd0 : sel_q + 2'd1;
                        KEY_ENTER: begin
                            if (sel_q != 2'd0) begin
                                state_d      = ST_SUB;
                                menu_state_d = {2'b00, sel_q};
                            end
                        end
                        default: ;
                    endcase
                end
                default: begin
                    if (key == KEY_ESC) begin
                        state_d      = ST_MAIN;
                        menu_state_d = 4'd0;
                    end
                end
            endcase
        end
    end

    // Cursor redraw is deferred to the frame origin so a box never tears.
    always_comb begin
        key_prev_d = key;
        disp_sel_d = ((in.vcount == 11'd0) && (in.hcount == 11'd0)) ? sel_q : disp_sel_q;
        hcount_d   = in.hcount;
        vcount_d   = in.vcount;
        hsync_d    = in.hsync;
        vsync_d    = in.vsync;
        hblnk_d    = in.hblnk;
        vblnk_d    = in.vblnk;
    end

    always_comb begin
        rgb_d = BG_RGB;
        if (in.vblnk || in.hblnk) begin
            rgb_d = 12'h000;
        end else if (state_q == ST_SUB) begin
            rgb_d = in_panel ? PANEL_RGB : BG_RGB;
        end else begin
            for (int i = 0; i < N_ITEMS; i++) begin
                if (in_box[i]) begin
                    rgb_d = (2'(i) == disp_sel_q) ? SEL_RGB : ITEM_RGB;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_MAIN;
            sel_q        <= 2'd0;
            disp_sel_q   <= 2'd0;
            key_prev_q   <= KEY_NONE;
            menu_state_q <= 4'd0;
            rgb_q        <= 12'h000;
            hcount_q     <= 11'd0;
            vcount_q     <= 11'd0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            hblnk_q      <= 1'b0;
            vblnk_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            disp_sel_q   <= disp_sel_d;
            key_prev_q   <= key_prev_d;
            menu_state_q <= menu_state_d;
            rgb_q        <= rgb_d;
            hcount_q     <= hcount_d;
            vcount_q     <= vcount_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            hblnk_q      <= hblnk_d;
            vblnk_q      <= vblnk_d;
        end
    end

    assign out.rgb    = rgb_q;
    assign out.hcount = hcount_q;
    assign out.vcount = vcount_q;
    assign out.hsync  = hsync_q;
    assign out.vsync  = vsync_q;
    assign out.hblnk  = hblnk_q;
    assign out.vblnk  = vblnk_q;
    assign menu_state = menu_state_q;

endmodule

`default_nettype wire

// File: tb/tb_menu_screen.sv
// ============================================================================
//  tb_menu_screen
//  Scoreboard bench for menu_screen driven by directed pixel/key vectors.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_menu_screen;

    localparam logic [3:0] K_NONE  = 4'h0;
    localparam logic [3:0] K_UP    = 4'h2;
    localparam logic [3:0] K_DOWN  = 4'h3;
    localparam logic [3:0] K_ENTER = 4'h4;
    localparam logic [3:0] K_ESC   = 4'hF;
    localparam logic [11:0] BG    = 12'h113;
    localparam logic [11:0] ITEM  = 12'h888;
    localparam logic [11:0] SEL   = 12'hFF0;
    localparam logic [11:0] PANEL = 12'h046;

    typedef struct packed {
        logic [11:0] rgb;
        logic [3:0]  ms;
        logic [10:0] hc;
        logic [10:0] vc;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key = 4'h0;
    logic [3:0] menu_state;
    logic       vld = 1'b0;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_vec   = 0;
    exp_t       q[$];

    vga_if vin();
    vga_if vout();

    menu_screen dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key),
        .in         (vin),
        .out        (vout),
        .menu_state (menu_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Monitor: output registered from a valid vector is compared on the following negedge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (vld) begin
                @(negedge clk);
                if (q.size() == 0) begin
                    check("queue_underflow", n_vec, 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("rgb", n_vec, 32'(vout.rgb), 32'(e.rgb));
                    check("menu_state", n_vec, 32'(menu_state), 32'(e.ms));
                    check("timing", n_vec,
                          32'({vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}),
                          32'({e.hc, e.vc, e.hs, e.vs, e.hb, e.vb}));
                end
                n_vec++;
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            vin.hcount = 11'd1100; vin.vcount = 11'd5;
            vin.hblnk = 1'b1; vin.vblnk = 1'b0;
            vin.hsync = 1'b0; vin.vsync = 1'b0; vin.rgb = 12'h000;
            vld = 1'b0;
        end
    endtask

    task automatic px(input logic [10:0] h, input logic [10:0] v, input logic hb, input logic vb,
                      input logic [3:0] k, input logic r, input logic [11:0] e_rgb, input logic [3:0] e_ms);
        exp_t e;
        @(posedge clk); #1;
        vin.hcount = h; vin.vcount = v; vin.hblnk = hb; vin.vblnk = vb;
        vin.hsync = h[1]; vin.vsync = v[2]; vin.rgb = 12'hABC;
        key = k; rst = r; vld = 1'b1;
        if (r) begin
            e = '0;
        end else begin
            e.rgb = e_rgb; e.ms = e_ms; e.hc = h; e.vc = v;
            e.hs = h[1]; e.vs = v[2]; e.hb = hb; e.vb = vb;
        end
        q.push_back(e);
    endtask

    task automatic chk_px(input logic [10:0] h, input logic [10:0] v, input logic [11:0] e_rgb, input logic [3:0] e_ms);
        px(h, v, 1'b0, 1'b0, K_NONE, 1'b0, e_rgb, e_ms);
    endtask

    task automatic frame_start(input logic [3:0] e_ms);
        px(11'd0, 11'd0, 1'b0, 1'b0, K_NONE, 1'b0, BG, e_ms);
    endtask

    task automatic press(input logic [3:0] k, input int hold);
        idle(1);
        key = k;
        idle(hold);
        key = K_NONE;
        idle(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(2);
        // Reset: every output field reads zero
        px(11'd300, 11'd300, 1'b0, 1'b0, K_NONE, 1'b1, 12'h0, 4'h0);
        px(11'd7,   11'd6,   1'b1, 1'b1, K_NONE, 1'b1, 12'h0, 4'h0);
        px(11'd420, 11'd210, 1'b0, 1'b0, K_NONE, 1'b1, 12'h0, 4'h0);

        // First frame, cursor on item 0; box boundaries
        frame_start(4'd0);
        chk_px(11'd420, 11'd210, SEL, 4'd0);
        chk_px(11'd420, 11'd330, ITEM, 4'd0);
        chk_px(11'd10,  11'd10,  BG, 4'd0);
        px(11'd420, 11'd210, 1'b1, 1'b0, K_NONE, 1'b0, 12'h000, 4'd0);
        px(11'd420, 11'd210, 1'b0, 1'b1, K_NONE, 1'b0, 12'h000, 4'd0);
        chk_px(11'd411, 11'd210, BG, 4'd0);
        chk_px(11'd412, 11'd200, SEL, 4'd0);
        chk_px(11'd611, 11'd279, SEL, 4'd0);
        chk_px(11'd612, 11'd210, BG, 4'd0);
        chk_px(11'd420, 11'd280, BG, 4'd0);
        chk_px(11'd420, 11'd199, BG, 4'd0);
        chk_px(11'd420, 11'd440, ITEM, 4'd0);
        chk_px(11'd420, 11'd519, ITEM, 4'd0);
        chk_px(11'd420, 11'd520, BG, 4'd0);

        // Held DOWN: one event; highlight moves only at next frame origin
        press(K_DOWN, 500);
        chk_px(11'd420, 11'd210, SEL, 4'd0);
        chk_px(11'd420, 11'd330, ITEM, 4'd0);
        frame_start(4'd0);
        chk_px(11'd420, 11'd330, SEL, 4'd0);
        chk_px(11'd420, 11'd210, ITEM, 4'd0);
        chk_px(11'd420, 11'd450, ITEM, 4'd0);

        // Wrap-around both ways
        press(K_UP, 3);
        press(K_UP, 3);
        frame_start(4'd0);
        chk_px(11'd420, 11'd450, SEL, 4'd0);
        chk_px(11'd420, 11'd210, ITEM, 4'd0);
        chk_px(11'd420, 11'd330, ITEM, 4'd0);
        press(K_DOWN, 3);
        frame_start(4'd0);
        chk_px(11'd420, 11'd210, SEL, 4'd0);
        chk_px(11'd420, 11'd450, ITEM, 4'd0);
        press(K_UP, 3);
        frame_start(4'd0);

        // ENTER on item 2: menu_state follows one clk after the event
        chk_px(11'd420, 11'd450, SEL, 4'd0);
        px(11'd420, 11'd210, 1'b0, 1'b0, K_ENTER, 1'b0, ITEM, 4'd2);
        chk_px(11'd420, 11'd210, PANEL, 4'd2);
        chk_px(11'd500, 11'd400, PANEL, 4'd2);
        chk_px(11'd99,  11'd400, BG, 4'd2);
        chk_px(11'd100, 11'd100, PANEL, 4'd2);
        chk_px(11'd923, 11'd667, PANEL, 4'd2);
        chk_px(11'd924, 11'd400, BG, 4'd2);
        chk_px(11'd500, 11'd668, BG, 4'd2);
        press(K_UP, 3);
        press(K_DOWN, 3);
        press(K_ENTER, 3);
        chk_px(11'd500, 11'd400, PANEL, 4'd2);
        chk_px(11'd420, 11'd450, PANEL, 4'd2);
        press(K_ESC, 3);
        chk_px(11'd420, 11'd450, SEL, 4'd0);
        chk_px(11'd420, 11'd210, ITEM, 4'd0);
        chk_px(11'd500, 11'd400, BG, 4'd0);

        // ENTER on item 0 does nothing
        press(K_DOWN, 3);
        frame_start(4'd0);
        press(K_ENTER, 3);
        chk_px(11'd420, 11'd210, SEL, 4'd0);
        chk_px(11'd500, 11'd400, BG, 4'd0);

        // Reset for one clk while in a submenu
        press(K_DOWN, 3);
        press(K_ENTER, 3);
        chk_px(11'd500, 11'd400, PANEL, 4'd1);
        px(11'd500, 11'd400, 1'b0, 1'b0, K_NONE, 1'b1, 12'h0, 4'h0);
        chk_px(11'd500, 11'd400, BG, 4'd0);
        chk_px(11'd420, 11'd210, SEL, 4'd0);
        press(K_DOWN, 3);
        frame_start(4'd0);
        chk_px(11'd420, 11'd330, SEL, 4'd0);
        chk_px(11'd420, 11'd210, ITEM, 4'd0);

        idle(4);
        check("queue_empty", n_vec, 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/menu_screen.md
Name: menu_screen

Overview:
- Generates the main-menu picture and menu navigation state.
- Sits upstream of the menu/game output selector:
  - consumes VGA timing from the timing generator;
  - consumes the filtered key code the selector passes back (key_menu);
  - produces the menu-side VGA stream and menu_state.
- menu_state 0 = main menu. The selector starts the game only when menu_state is 0, so this block must return to 0 on escape.

Parameters:
- KEY_NONE, 4'h0, idle key code
- KEY_UP, 4'h2, cursor up
- KEY_DOWN, 4'h3, cursor down
- KEY_ENTER, 4'h4, open selected submenu
- KEY_ESC, 4'hF, return to main menu
- N_ITEMS, 3, number of menu items (2..4)
- ITEM_X, 412, left edge of item boxes (pixels)
- ITEM_Y0, 200, top edge of item 0
- ITEM_PITCH, 120, vertical distance between item tops
- ITEM_W, 200, box width
- ITEM_H, 80, box height
- BG_RGB, 12'h113, background colour
- ITEM_RGB, 12'h888, unselected box colour
- SEL_RGB, 12'hFF0, selected box colour
- PANEL_RGB, 12'h046, submenu panel colour

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- key  in  4  key code from selector (key_menu); level, held while pressed
- in  vga_if.in  -  timing from generator (vcount, vsync, vblnk, hcount, hsync, hblnk; rgb ignored)
- out  vga_if.out  -  menu picture with delayed timing
- menu_state  out  4  0 = main, 1..N_ITEMS-1 = submenu index

Behaviour:
- Reset: all out fields 0; menu_state 0; state MAIN; cursor sel 0; displayed cursor disp_sel 0; key_prev = KEY_NONE.
- Key event:
  - Asserted for one clk when key != key_prev and key != KEY_NONE.
  - key_prev is registered every clk.
  - A held key generates exactly one event.
  - Unknown codes are events with no effect.
- State machine, in MAIN:
  - KEY_UP: sel = sel-1, wrapping 0 -> N_ITEMS-1.
  - KEY_DOWN: sel = sel+1, wrapping N_ITEMS-1 -> 0.
  - KEY_ENTER with sel != 0: go to SUB, menu_state <= sel.
  - KEY_ENTER with sel == 0: no action (game start belongs to the selector).
  - KEY_ESC: no action.
- State machine, in SUB:
  - Only KEY_ESC acts: go to MAIN, menu_state <= 0, sel unchanged.
  - UP/DOWN/ENTER ignored.
- menu_state is registered and updates the clk after the event.
- Tear-free cursor:
  - disp_sel <= sel only on the clk where in.vcount == 0 and in.hcount == 0.
  - Drawing uses disp_sel.
  - State changes take effect immediately.
- Pixel pipeline, 1 clk latency:
  - Every out timing field equals the in field delayed 1 clk.
  - out.rgb is computed from the same-cycle in.hcount/in.vcount and registered.
- Colour priority:
  1. in.vblnk or in.hblnk -> 12'h000.
  2. State SUB: PANEL_RGB inside 100 <= hcount < 924 and 100 <= vcount < 668, else BG_RGB.
  3. State MAIN, pixel inside box i (ITEM_X <= hcount < ITEM_X+ITEM_W, ITEM_Y0+i*ITEM_PITCH <= vcount < that + ITEM_H): SEL_RGB if i == disp_sel, else ITEM_RGB.
  4. Otherwise BG_RGB.
- Arithmetic:
  - Box bounds are computed in 11-bit unsigned, constant-folded from parameters; no runtime multiply.
  - Bounds are inclusive-low / exclusive-high.
- Reset mid-frame: outputs go to 0 the next clk and resume 1 clk after rst deasserts; cursor returns to 0.
- A key change in the same clk as a state transition: only the current state's rules apply; one event per clk.

Test Plan:
- Reset, then run 1 frame -> all outputs 0 during rst; afterwards out.hsync/vsync equal in delayed exactly 1 clk; pixel (420,210) = SEL_RGB 12'hFF0; pixel (420,330) = ITEM_RGB 12'h888; pixel (10,10) = BG_RGB 12'h113.
- KEY_DOWN held 500 clks mid-frame -> sel = 1 (single event); pixel (420,210) stays 12'hFF0 until the next frame start; in the next frame (420,330) = 12'hFF0 and (420,210) = 12'h888.
- KEY_UP pulse from sel 0 -> sel = 2 (wrap); KEY_DOWN pulse from 2 -> sel = 0.
- sel = 2, KEY_ENTER -> menu_state = 2 one clk after the event; pixel (500,400) = 12'h046; UP/DOWN/ENTER then ignored; KEY_ESC -> menu_state = 0; box drawing returns with sel 2 highlighted.
- sel = 0, KEY_ENTER -> menu_state stays 0; state stays MAIN.
- Blanking: any pixel with hblnk or vblnk set -> out.rgb = 12'h000. Assert rst for 1 clk mid-line while in SUB -> menu_state = 0, sel = 0, outputs 0 for that clk.
